clock_ratio_meter: RTL and testbench



---
 rtl/clk_meter_pkg.sv | 20 ++
 rtl/sync_edge_detect.sv | 41 ++++
 rtl/clock_ratio_meter.sv | 174 +++++++++++++++++
 tb/tb_clock_ratio_meter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// ---------------------------------------------------------------------------
// clk_meter_pkg
// Shared types and constants for clock_ratio_meter and its front end.
//   state_t              : measurement FSM states (IDLE, MEASURE)
//   DEFAULT_CNT_W        : default width of the period/high-time counters
//   DEFAULT_SYNC_STAGES  : default synchronizer depth on the measured input
//   AVG_DEPTH            : number of raw periods averaged when averaging is built in
// ---------------------------------------------------------------------------
package clk_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int DEFAULT_CNT_W       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int AVG_DEPTH           = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous slow clock into the clk_in domain and flags its
// rising edges.
//   clk_in  in   system clock, rising edge
//   rst     in   synchronous active-high reset, clears the whole chain
//   sig_in  in   asynchronous input
//   level   out  synchronized copy of sig_in (SYNC_STAGES cycles late)
//   rise    out  one-cycle pulse on a 0->1 transition of level
// SYNC_STAGES must be 2 or 3.
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk_in) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour; blocking here would
        // collapse the synchronizer chain into a single stage.
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/clock_ratio_meter.sv
// ---------------------------------------------------------------------------
// clock_ratio_meter
// Measures period and high time of a slow input clock in clk_in cycles.
//   clk_in     in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   measurement enable; low returns the meter to IDLE
//   sig_in     in   asynchronous slow clock under measurement
//   period     out  clk_in cycles between the last two rising edges of sig_in
//   high_time  out  clk_in cycles sig_in was high within that period
//   valid      out  one-cycle pulse when period/high_time update
//   locked     out  last two measured raw periods were equal
//   timeout    out  counter saturated in MEASURE without a rising edge
// Build option CLK_METER_AVG_EN: period becomes the truncated mean of the
// last AVG_DEPTH raw periods and valid is held off until AVG_DEPTH
// measurements have completed since IDLE. high_time and locked stay raw.
// ---------------------------------------------------------------------------
module clock_ratio_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             level;
    logic             rise;
    state_t           state, state_next;
    logic             done;        // rising edge closes a measurement
    logic             sat;         // counter saturated, give up on this input
    logic             report;      // completed measurement is published
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] last_raw;
    logic             have_prev;
    logic [CNT_W-1:0] period_next;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .level  (level),
        .rise   (rise)
    );

    always_ff @(posedge clk_in) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        done       = 1'b0;
        sat        = 1'b0;
        case (state)
            IDLE: begin
                if (en && rise) state_next = MEASURE;
            end
            MEASURE: begin
                // en beats rise, and rise beats saturation.
                if (!en) begin
                    state_next = IDLE;
                end else if (rise) begin
                    done = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    sat        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The cycle that sees the edge is counted as the first cycle of the new
    // period, hence the restart value of one.
    always_ff @(posedge clk_in) begin
        if (rst || state_next == IDLE) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (state == IDLE || done) begin
            cnt  <= CNT_ONE;
            hcnt <= CNT_ONE;
        end else begin
            cnt  <= cnt + CNT_ONE;
            hcnt <= hcnt + {{(CNT_W-1){1'b0}}, level};
        end
    end

    // Previous raw period for lock detection; forgotten whenever the meter
    // drops back to IDLE so the first result after IDLE never claims lock.
    always_ff @(posedge clk_in) begin
        if (rst || state_next == IDLE) begin
            have_prev <= 1'b0;
            last_raw  <= '0;
        end else if (done) begin
            have_prev <= 1'b1;
            last_raw  <= cnt;
        end
    end

`ifdef CLK_METER_AVG_EN
    localparam int SUM_W = CNT_W + 2;
    localparam int N_W   = $clog2(AVG_DEPTH);
    localparam logic [N_W-1:0] N_FULL = N_W'(AVG_DEPTH - 1);

    logic [CNT_W-1:0] hist [AVG_DEPTH];
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;
    logic [N_W-1:0]   n_meas;

    // Running sum: add the newest raw period, drop the one shifted out.
    assign sum_next    = sum + SUM_W'(cnt) - SUM_W'(hist[AVG_DEPTH-1]);
    assign period_next = CNT_W'(sum_next >> N_W);
    assign report      = done && (n_meas == N_FULL);

    always_ff @(posedge clk_in) begin
        // NOTE: the history is only four words and the running sum relies on
        // it starting at zero, so it is cleared like any other register
        // rather than left as an unreset memory.
        if (rst || state_next == IDLE) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
            sum    <= '0;
            n_meas <= '0;
        end else if (done) begin
            hist[0] <= cnt;
            for (int i = 1; i < AVG_DEPTH; i++) hist[i] <= hist[i-1];
            sum <= sum_next;
            if (n_meas != N_FULL) n_meas <= n_meas + 1'b1;
        end
    end
`else
    assign period_next = cnt;
    assign report      = done;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= report;
            if (report) begin
                period    <= period_next;
                high_time <= hcnt;
                locked    <= have_prev && (cnt == last_raw);
                timeout   <= 1'b0;
            end else if (sat) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
            end else if (!en) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// ---------------------------------------------------------------------------
// tb_clock_ratio_meter
// Self-checking bench for clock_ratio_meter (CNT_W=8, SYNC_STAGES=2).
// sig_in/en/rst are driven one clk_in cycle at a time by step(); a cycle
// model of the meter, running in the stimulus domain, pushes the expected
// result of every completed measurement to a queue. A monitor pops and
// compares whenever valid is seen. Scenario tasks add direct checks on
// timing, lock and timeout behaviour.
// ---------------------------------------------------------------------------
module tb_clock_ratio_meter;

    localparam int W       = 8;
    localparam int CNT_MAX = (1 << W) - 1;
`ifdef CLK_METER_AVG_EN
    localparam int RESUME_PERIODS = 4;
`else
    localparam int RESUME_PERIODS = 1;
`endif

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         en     = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         locked;
    logic         timeout;

    clock_ratio_meter #(
        .CNT_W       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] period;
        logic [W-1:0] high_time;
        logic         locked;
        logic         timeout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int   checks         = 0;
    int   errors         = 0;
    int   cyc            = 0;
    int   valid_count    = 0;
    int   last_valid_cyc = 0;
    int   last_spacing   = 0;
    logic prev_valid     = 1'b0;

    // Model state (stimulus domain).
    logic m_last_v    = 1'b0;
    bit   m_meas      = 1'b0;
    bit   m_have_prev = 1'b0;
    int   m_cnt       = 0;
    int   m_hcnt      = 0;
    int   m_prev      = 0;
    int   m_pushes    = 0;
    int   m_hist [4]  = '{0, 0, 0, 0};
    int   m_n         = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard consumer.
    always @(negedge clk_in) begin
        if (valid === 1'b1) begin
            checks++;
            if (prev_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_back_to_back: valid high in consecutive cycles at cycle %0d", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: valid at cycle %0d, period=%0d high_time=%0d, no result expected",
                         cyc, period, high_time);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (period !== mon_e.period) begin
                    errors++;
                    $display("FAIL sb_period: got %0d, expected %0d (cycle %0d)", period, mon_e.period, cyc);
                end
                checks++;
                if (high_time !== mon_e.high_time) begin
                    errors++;
                    $display("FAIL sb_high_time: got %0d, expected %0d (cycle %0d)", high_time, mon_e.high_time, cyc);
                end
                checks++;
                if (locked !== mon_e.locked) begin
                    errors++;
                    $display("FAIL sb_locked: got %b, expected %b (cycle %0d)", locked, mon_e.locked, cyc);
                end
                checks++;
                if (timeout !== mon_e.timeout) begin
                    errors++;
                    $display("FAIL sb_timeout: got %b, expected %b (cycle %0d)", timeout, mon_e.timeout, cyc);
                end
            end
            last_spacing   = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            valid_count++;
        end
        prev_valid = valid;
    end

    task automatic clear_hist();
        for (int i = 0; i < 4; i++) m_hist[i] = 0;
        m_n = 0;
    endtask

    // A rising edge closed a measurement of m_cnt cycles, m_hcnt of them high.
    task automatic finish_meas();
        exp_t e;
        int   s;
        bit   rep;
`ifdef CLK_METER_AVG_EN
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_cnt;
        if (m_n < 4) m_n++;
        s   = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
        rep = (m_n == 4);
`else
        s   = m_cnt;
        rep = 1'b1;
`endif
        if (rep) begin
            e.period    = W'(s);
            e.high_time = W'(m_hcnt);
            e.locked    = m_have_prev && (m_cnt == m_prev);
            e.timeout   = 1'b0;
            exp_q.push_back(e);
            m_pushes++;
        end
        m_prev      = m_cnt;
        m_have_prev = 1'b1;
        m_cnt       = 1;
        m_hcnt      = 1;
    endtask

    // Drive one clk_in cycle of inputs and advance the model by that cycle.
    task automatic step(input logic v, input logic e, input logic r);
        logic rise_m;
        rise_m = v && !m_last_v;
        if (r) begin
            m_meas = 1'b0; m_have_prev = 1'b0; clear_hist();
        end else if (!e) begin
            m_meas = 1'b0; m_have_prev = 1'b0; clear_hist();
        end else if (m_meas) begin
            if (rise_m) begin
                finish_meas();
            end else if (m_cnt == CNT_MAX) begin
                m_meas = 1'b0; m_have_prev = 1'b0; clear_hist();
            end else begin
                m_cnt++;
                if (v) m_hcnt++;
            end
        end else if (rise_m) begin
            m_meas = 1'b1; m_cnt = 1; m_hcnt = 1;
        end
        m_last_v = v;
        sig_in = v;
        en     = e;
        rst    = r;
        @(posedge clk_in);
        #1;
    endtask

    task automatic square(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < lo; i++) step(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic go_idle();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            step(sig_in, en, 1'b0);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected results never reported", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (period !== '0 || high_time !== '0 || valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s: period=%0d high_time=%0d valid=%b locked=%b timeout=%b, all required 0",
                     name, period, high_time, valid, locked, timeout);
        end
    endtask

    task automatic test_reset();
        int vc0, p0;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check_all_zero("reset_initial");
        repeat (2) step(1'b0, 1'b1, 1'b0);
        vc0 = valid_count;
        p0  = m_pushes;
        square(4, 4, 4);
        drain("reset_pre");
        checks++;
        if (valid_count - vc0 !== m_pushes - p0) begin
            errors++;
            $display("FAIL reset_pre_valids: got %0d valids, expected %0d", valid_count - vc0, m_pushes - p0);
        end
        step(1'b0, 1'b1, 1'b1);
        check_all_zero("reset_mid_measure");
        step(1'b0, 1'b1, 1'b0);
        vc0 = valid_count;
        square(4, 4, 1);
        checks++;
        if (valid_count !== vc0) begin
            errors++;
            $display("FAIL reset_one_edge: got %0d valids after one fresh edge, expected 0", valid_count - vc0);
        end
        square(4, 4, 1);
        drain("reset_post");
    endtask

    task automatic test_ratio8();
        go_idle();
        square(4, 4, 6);
        drain("ratio8");
        checks++;
        if (last_spacing !== 8) begin
            errors++;
            $display("FAIL ratio8_spacing: got %0d cycles between valids, expected 8", last_spacing);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL ratio8_locked: got %b, expected 1", locked);
        end
    endtask

    task automatic test_duty_change();
        square(2, 4, 3);
        drain("duty");
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL duty_relock: got %b, expected 1", locked);
        end
    endtask

    task automatic test_timeout();
        int k, vc0;
        go_idle();
        square(4, 4, 4);
        k = 0;
        while (timeout !== 1'b1 && k < 300) begin
            step(1'b1, 1'b1, 1'b0);
            k++;
        end
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_seen: timeout=%b after %0d high cycles, expected 1", timeout, k);
        end else begin
            // The valid pulse and cnt=1 share a cycle; cnt reaches 255 254
            // cycles later and timeout shows one cycle after that.
            checks++;
            if (cyc - last_valid_cyc !== CNT_MAX) begin
                errors++;
                $display("FAIL timeout_delay: got %0d cycles after valid, expected %0d",
                         cyc - last_valid_cyc, CNT_MAX);
            end
        end
        checks++;
        if (locked !== 1'b0 || period !== 8'd8 || high_time !== 8'd4) begin
            errors++;
            $display("FAIL timeout_hold: locked=%b period=%0d high_time=%0d, expected 0/8/4",
                     locked, period, high_time);
        end
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        vc0 = valid_count;
        square(4, 4, 1);
        checks++;
        if (timeout !== 1'b1 || valid_count !== vc0) begin
            errors++;
            $display("FAIL timeout_sticky: timeout=%b valids=%0d, expected 1/0", timeout, valid_count - vc0);
        end
        square(4, 4, RESUME_PERIODS);
        drain("timeout_resume");
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b, expected 0", timeout);
        end
    endtask

    task automatic test_enable();
        int vc0;
        go_idle();
        square(4, 4, 3);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop: locked=%b timeout=%b, expected 0/0", locked, timeout);
        end
        drain("enable_pre");
        repeat (3) step(1'b0, 1'b1, 1'b0);
        vc0 = valid_count;
        square(4, 4, 1);
        checks++;
        if (valid_count !== vc0) begin
            errors++;
            $display("FAIL enable_one_edge: got %0d valids, expected 0", valid_count - vc0);
        end
        square(4, 4, 1);
        drain("enable_post");
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL enable_first_locked: got %b, expected 0", locked);
        end
    endtask

`ifdef CLK_METER_AVG_EN
    task automatic test_avg();
        int vc0;
        go_idle();
        vc0 = valid_count;
        square(4, 4, 3);
        square(6, 6, 1);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        drain("avg");
        checks++;
        if (valid_count - vc0 !== 1 || period !== 8'd9 || high_time !== 8'd6 || locked !== 1'b0) begin
            errors++;
            $display("FAIL avg_result: valids=%0d period=%0d high_time=%0d locked=%b, expected 1/9/6/0",
                     valid_count - vc0, period, high_time, locked);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ratio8();
        test_duty_change();
        test_timeout();
        test_enable();
`ifdef CLK_METER_AVG_EN
        test_avg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
